parking_code_entry: RTL and testbench

Front-end stage that feeds the parking-gate controller.
- Debounces the raw entrance and exit car sensors.
- Collects a two-digit code (2 bits per digit) from the keypad scanner's strobe interface.
- Presents stable sensor_entrance, sensor_exit, password_1 and password_2 to the gate FSM, plus a code_ready qualifier.

---
 rtl/parking_pkg.sv | 23 ++
 rtl/parking_debounce.sv | 33 +++
 rtl/parking_code_entry.sv | 147 ++++++++++++++
 tb/tb_parking_code_entry.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and default timing constants for the parking-gate front end.
// Also used by the gate controller so both agree on state encoding and timing.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIGIT1 = 3'd1,
        DIGIT2 = 3'd2,
        READY  = 3'd3,
        LOCKED = 3'd4
    } entry_state_t;

    typedef logic [1:0] digit_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int unsigned ENTRY_TIMEOUT_DEFAULT   = 1000;
    localparam int unsigned MAX_RETRIES_DEFAULT     = 3;

    function automatic logic is_entering(input entry_state_t s);
        return (s == DIGIT1) || (s == DIGIT2);
    endfunction

endpackage

// File: rtl/parking_debounce.sv
// Single-bit debouncer: dout follows din only after din has differed from
// dout for DEBOUNCE_CYCLES consecutive samples (DEBOUNCE_CYCLES >= 2).
module parking_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff reads the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            dout  <= 1'b0;
        end else if (din == dout) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
            dout  <= din;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/parking_code_entry.sv
// Front end of the parking gate: debounced car sensors and two-digit code capture.
// Build option PARKING_LOCKOUT_EN adds a retry counter and a LOCKED state.
module parking_code_entry
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned ENTRY_TIMEOUT   = ENTRY_TIMEOUT_DEFAULT,
    parameter int unsigned MAX_RETRIES     = MAX_RETRIES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw_entrance,
    input  logic       raw_exit,
    input  logic       key_valid,
    input  logic [1:0] key_digit,
    input  logic       key_clear,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       code_ready,
    output logic       entry_busy,
    output logic       lockout
);

    localparam int unsigned          TIMER_W    = $clog2(ENTRY_TIMEOUT);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(ENTRY_TIMEOUT - 1);

    entry_state_t       state_q, state_d;
    digit_t             pw1_q, pw1_d, pw2_q, pw2_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               entrance_q;
    logic               entrance_rise;
    logic               in_digit;

`ifdef PARKING_LOCKOUT_EN
    localparam int unsigned          RETRY_W     = $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0]   RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    logic [RETRY_W-1:0] retry_q, retry_d;
`endif

    parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_entrance (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (raw_entrance),
        .dout    (sensor_entrance)
    );

    parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_exit (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (raw_exit),
        .dout    (sensor_exit)
    );

    assign entrance_rise = sensor_entrance & ~entrance_q;
    assign in_digit      = is_entering(state_q);
    assign password_1    = pw1_q;
    assign password_2    = pw2_q;

    // Priority: car gone > key_clear > timeout > key_valid.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_d = state_q;
        pw1_d   = pw1_q;
        pw2_d   = pw2_q;
        timer_d = '0;
`ifdef PARKING_LOCKOUT_EN
        retry_d = retry_q;
`endif

        if (state_q == IDLE) begin
            if (entrance_rise) begin
                state_d = DIGIT1;
            end
        end else if (!sensor_entrance) begin
            state_d = IDLE;
            pw1_d   = '0;
            pw2_d   = '0;
`ifdef PARKING_LOCKOUT_EN
            retry_d = '0;
        end else if (state_q == LOCKED) begin
            state_d = LOCKED;
`endif
        end else if (key_clear) begin
            state_d = DIGIT1;
            pw1_d   = '0;
            pw2_d   = '0;
`ifdef PARKING_LOCKOUT_EN
            retry_d = retry_q + 1'b1;
            if (retry_d == RETRY_LIMIT) begin
                state_d = LOCKED;
            end
`endif
        end else if (in_digit && (timer_q == TIMER_LAST)) begin
            state_d = DIGIT1;
            pw1_d   = '0;
            pw2_d   = '0;
        end else if (key_valid && (state_q == DIGIT1)) begin
            pw1_d   = key_digit;
            state_d = DIGIT2;
        end else if (key_valid && (state_q == DIGIT2)) begin
            pw2_d   = key_digit;
            state_d = READY;
        end else if (in_digit) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Status outputs decode the next state so they line up with the transition edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pw1_q      <= '0;
            pw2_q      <= '0;
            timer_q    <= '0;
            entrance_q <= 1'b0;
            code_ready <= 1'b0;
            entry_busy <= 1'b0;
        end else begin
            state_q    <= state_d;
            pw1_q      <= pw1_d;
            pw2_q      <= pw2_d;
            timer_q    <= timer_d;
            entrance_q <= sensor_entrance;
            code_ready <= (state_d == READY);
            entry_busy <= is_entering(state_d);
        end
    end

`ifdef PARKING_LOCKOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retry_q <= '0;
            lockout <= 1'b0;
        end else begin
            retry_q <= retry_d;
            lockout <= (state_d == LOCKED);
        end
    end
`else
    assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_parking_code_entry.sv
// Self-checking bench for parking_code_entry with default parameters.
// Expectations adapt to whether PARKING_LOCKOUT_EN is defined.
module tb_parking_code_entry;

    typedef struct packed {
        logic       se;
        logic       sx;
        logic [1:0] p1;
        logic [1:0] p2;
        logic       rdy;
        logic       busy;
        logic       lk;
    } obs_t;

    typedef struct {
        string      name;
        logic       kv;
        logic [1:0] kd;
        logic       kc;
        obs_t       exp;
    } vec_t;

`ifdef PARKING_LOCKOUT_EN
    localparam logic LK = 1'b1;
`else
    localparam logic LK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       raw_entrance;
    logic       raw_exit;
    logic       key_valid;
    logic [1:0] key_digit;
    logic       key_clear;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       code_ready;
    logic       entry_busy;
    logic       lockout;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    vec_t vecs[9];
    obs_t zero_obs;

    parking_code_entry dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .raw_entrance    (raw_entrance),
        .raw_exit        (raw_exit),
        .key_valid       (key_valid),
        .key_digit       (key_digit),
        .key_clear       (key_clear),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .password_1      (password_1),
        .password_2      (password_2),
        .code_ready      (code_ready),
        .entry_busy      (entry_busy),
        .lockout         (lockout)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic se, input logic sx, input logic [1:0] p1,
                                input logic [1:0] p2, input logic rdy, input logic busy,
                                input logic lk);
        obs_t o;
        o.se = se; o.sx = sx; o.p1 = p1; o.p2 = p2;
        o.rdy = rdy; o.busy = busy; o.lk = lk;
        return o;
    endfunction

    function automatic obs_t cur();
        return {sensor_entrance, sensor_exit, password_1, password_2,
                code_ready, entry_busy, lockout};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got se=%b sx=%b p1=%b p2=%b rdy=%b busy=%b lock=%b, want se=%b sx=%b p1=%b p2=%b rdy=%b busy=%b lock=%b",
                     name, act.se, act.sx, act.p1, act.p2, act.rdy, act.busy, act.lk,
                     exp.se, exp.sx, exp.p1, exp.p2, exp.rdy, exp.busy, exp.lk);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of strobes, then compare the DUT against the queued expectation.
    task automatic cycle(input string name, input logic kv, input logic [1:0] kd,
                         input logic kc, input obs_t exp);
        obs_t e;
        key_valid = kv;
        key_digit = kd;
        key_clear = kc;
        exp_q.push_back(exp);
        step();
        key_valid = 1'b0;
        key_digit = 2'b00;
        key_clear = 1'b0;
        e = exp_q.pop_front();
        check(name, cur(), e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        zero_obs = '0;
        // Code entry from DIGIT1 with the car present.
        vecs[0] = '{"d1_key01",     1'b1, 2'b01, 1'b0, mk(1, 0, 2'b01, 2'b00, 0, 1, 0)};
        vecs[1] = '{"d2_idle",      1'b0, 2'b00, 1'b0, mk(1, 0, 2'b01, 2'b00, 0, 1, 0)};
        vecs[2] = '{"d2_key10",     1'b1, 2'b10, 1'b0, mk(1, 0, 2'b01, 2'b10, 1, 0, 0)};
        vecs[3] = '{"ready_ignore", 1'b1, 2'b11, 1'b0, mk(1, 0, 2'b01, 2'b10, 1, 0, 0)};
        vecs[4] = '{"ready_clear",  1'b0, 2'b00, 1'b1, mk(1, 0, 2'b00, 2'b00, 0, 1, 0)};
        vecs[5] = '{"d1_key11",     1'b1, 2'b11, 1'b0, mk(1, 0, 2'b11, 2'b00, 0, 1, 0)};
        vecs[6] = '{"d2_key_clear", 1'b1, 2'b01, 1'b1, mk(1, 0, 2'b00, 2'b00, 0, 1, 0)};
        vecs[7] = '{"d1_key10",     1'b1, 2'b10, 1'b0, mk(1, 0, 2'b10, 2'b00, 0, 1, 0)};
        vecs[8] = '{"d2_key01",     1'b1, 2'b01, 1'b0, mk(1, 0, 2'b10, 2'b01, 1, 0, 0)};

        raw_entrance = 1'b0;
        raw_exit     = 1'b0;
        key_valid    = 1'b0;
        key_digit    = 2'b00;
        key_clear    = 1'b0;
        reset_n      = 1'b1;
        #1 reset_n = 1'b0;
        #1 check("reset_async", cur(), zero_obs);
        repeat (3) step();
        check("reset_hold", cur(), zero_obs);
        reset_n = 1'b1;

        // Short entrance glitch never propagates.
        raw_entrance = 1'b1;
        repeat (10) step();
        raw_entrance = 1'b0;
        check("glitch_10", cur(), zero_obs);
        repeat (5) step();
        check("glitch_after", cur(), zero_obs);

        // Stable entrance: output flips on the 16th sample, FSM follows one cycle later.
        raw_entrance = 1'b1;
        repeat (15) step();
        check("deb_15", cur(), zero_obs);
        cycle("deb_16",    1'b0, 2'b00, 1'b0, mk(1, 0, 2'b00, 2'b00, 0, 0, 0));
        cycle("busy_next", 1'b0, 2'b00, 1'b0, mk(1, 0, 2'b00, 2'b00, 0, 1, 0));

        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].name, vecs[i].kv, vecs[i].kd, vecs[i].kc, vecs[i].exp);
        end

        // Car leaves: code held until the debounced sensor falls, then cleared.
        raw_entrance = 1'b0;
        repeat (15) step();
        check("leave_15", cur(), mk(1, 0, 2'b10, 2'b01, 1, 0, 0));
        cycle("leave_16",   1'b0, 2'b00, 1'b0, mk(0, 0, 2'b10, 2'b01, 1, 0, 0));
        cycle("leave_idle", 1'b0, 2'b00, 1'b0, zero_obs);

        // Timeout in DIGIT2.
        raw_entrance = 1'b1;
        repeat (16) step();
        cycle("reenter",   1'b0, 2'b00, 1'b0, mk(1, 0, 2'b00, 2'b00, 0, 1, 0));
        cycle("to_digit2", 1'b1, 2'b11, 1'b0, mk(1, 0, 2'b11, 2'b00, 0, 1, 0));
        repeat (998) step();
        cycle("timeout_999",  1'b0, 2'b00, 1'b0, mk(1, 0, 2'b11, 2'b00, 0, 1, 0));
        cycle("timeout_1000", 1'b0, 2'b00, 1'b0, mk(1, 0, 2'b00, 2'b00, 0, 1, 0));

        // Three clears in one session: lockout only in the lockout build.
        cycle("clr1", 1'b0, 2'b00, 1'b1, mk(1, 0, 2'b00, 2'b00, 0, 1, 0));
        cycle("clr2", 1'b0, 2'b00, 1'b1, mk(1, 0, 2'b00, 2'b00, 0, 1, 0));
        cycle("clr3", 1'b0, 2'b00, 1'b1, mk(1, 0, 2'b00, 2'b00, 0, ~LK, LK));
        cycle("key_after_clr3", 1'b1, 2'b01, 1'b0,
              mk(1, 0, LK ? 2'b00 : 2'b01, 2'b00, 0, ~LK, LK));
        cycle("clr4", 1'b0, 2'b00, 1'b1, mk(1, 0, 2'b00, 2'b00, 0, ~LK, LK));

        // Exit sensor debounces independently of the FSM.
        raw_exit = 1'b1;
        repeat (15) step();
        check("exit_15", cur(), mk(1, 0, 2'b00, 2'b00, 0, ~LK, LK));
        cycle("exit_16", 1'b0, 2'b00, 1'b0, mk(1, 1, 2'b00, 2'b00, 0, ~LK, LK));

        // Car leaves: lockout released on IDLE entry.
        raw_entrance = 1'b0;
        repeat (15) step();
        cycle("lock_leave_16", 1'b0, 2'b00, 1'b0, mk(0, 1, 2'b00, 2'b00, 0, ~LK, LK));
        cycle("lock_idle",     1'b0, 2'b00, 1'b0, mk(0, 1, 2'b00, 2'b00, 0, 0, 0));

        // Asynchronous reset from READY with password_1 = 10.
        raw_entrance = 1'b1;
        repeat (16) step();
        cycle("rst_enter", 1'b0, 2'b00, 1'b0, mk(1, 1, 2'b00, 2'b00, 0, 1, 0));
        cycle("rst_key10", 1'b1, 2'b10, 1'b0, mk(1, 1, 2'b10, 2'b00, 0, 1, 0));
        cycle("rst_key01", 1'b1, 2'b01, 1'b0, mk(1, 1, 2'b10, 2'b01, 1, 0, 0));
        #3 reset_n = 1'b0;
        #1 check("reset_mid", cur(), zero_obs);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        check("post_reset", cur(), zero_obs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
